// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a 3-sample majority vote per bit and a one-cycle valid strobe.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       iRX,
  output logic [7:0] oData,
  output logic       oValid
);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, HOLD} state_t;
  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] H = 16'(CLKS_PER_BIT / 2);
  state_t state, state_n;
  logic r1, rx_s, rx_d, s0, s1, s0_n, s1_n, valid_n, wrap, vote_at, vote;
  logic [15:0] timer, timer_n;
  logic [2:0] idx, idx_n;
  logic [7:0] sh, sh_n, data_n;
  assign wrap = timer == LAST;
  assign vote_at = timer == H + 16'd1;
  assign vote = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      {r1, rx_s, rx_d} <= 3'b111;
      state <= IDLE;
      timer <= '0;
      idx <= '0;
      {s0, s1} <= 2'b00;
      sh <= '0;
      oData <= '0;
      oValid <= 1'b0;
    end else begin
      {r1, rx_s, rx_d} <= {iRX, r1, rx_s};
      state <= state_n;
      timer <= timer_n;
      idx <= idx_n;
      {s0, s1} <= {s0_n, s1_n};
      sh <= sh_n;
      oData <= data_n;
      oValid <= valid_n;
    end
  end
  always_comb begin
    state_n = state;
    timer_n = wrap ? '0 : timer + 16'd1;
    idx_n = idx;
    sh_n = sh;
    data_n = oData;
    valid_n = 1'b0;
    s0_n = (timer == H - 16'd1) ? rx_s : s0;
    s1_n = (timer == H) ? rx_s : s1;
    case (state)
      IDLE: begin
        timer_n = (rx_d & ~rx_s) ? 16'd1 : '0;
        state_n = (rx_d & ~rx_s) ? START : IDLE;
      end
      START: begin
        if (vote_at && vote) begin
          state_n = IDLE;
          timer_n = '0;
        end else if (wrap) begin
          state_n = DATA;
          idx_n = '0;
        end
      end
      DATA: begin
        if (vote_at) sh_n[idx] = vote;
        if (wrap) begin
          idx_n = idx + 3'd1;
          state_n = (idx == 3'd7) ? STOP : DATA;
        end
      end
      STOP: begin
        if (vote_at) begin
          timer_n = '0;
          state_n = vote ? IDLE : HOLD;
          data_n = vote ? sh : oData;
          valid_n = vote;
        end
      end
      default: begin
        // framing error or break: stay out of IDLE until the line is high again
        timer_n = '0;
        state_n = rx_s ? IDLE : HOLD;
      end
    endcase
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized and directed frames against a queue-based expected-byte model.
module tb_uart_rx;
  localparam int C = 16;
  localparam int H = C / 2;
  typedef struct {
    logic [7:0] b;
    int t;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic iRX = 1'b1;
  logic [7:0] oData;
  logic oValid;
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int pulses = 0;
  logic [7:0] model_data = 8'h00;
  exp_t q[$];
  uart_rx #(.CLKS_PER_BIT(C)) dut (
    .clk(clk),
    .reset(reset),
    .iRX(iRX),
    .oData(oData),
    .oValid(oValid)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic bits(input int n);
    repeat (n * C) @(negedge clk);
  endtask
  task automatic send(input logic [7:0] b, input logic stop, input int gap, input int spike);
    if (stop) q.push_back('{b, cyc});
    iRX = 1'b0;
    bits(1);
    for (int i = 0; i < 8; i++) begin
      iRX = b[i];
      if (i == spike) begin
        repeat (H - 1) @(negedge clk);
        iRX = ~b[i];
        @(negedge clk);
        iRX = b[i];
        repeat (C - H) @(negedge clk);
      end else bits(1);
    end
    iRX = stop;
    bits(1);
    iRX = 1'b1;
    bits(gap);
  endtask
  task automatic drain(input string tag);
    bits(2);
    chk({tag, "_pending"}, q.size(), 0);
    chk({tag, "_hold"}, oData, model_data);
  endtask
  initial begin
    exp_t e;
    int d;
    forever begin
      @(negedge clk);
      if (oValid) begin
        pulses++;
        if (q.size() == 0) chk("spurious_pulse", q.size(), 1);
        else begin
          e = q.pop_front();
          d = cyc - e.t;
          chk("data", oData, e.b);
          chk("in_stop_bit", d >= 9 * C && d <= 10 * C + 4, 1);
          model_data = e.b;
        end
        @(negedge clk);
        chk("pulse_width", oValid, 0);
        chk("data_stable", oData, model_data);
      end
    end
  end
  initial begin
    logic [7:0] v;
    int p0;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      chk("rst_valid", oValid, 0);
      chk("rst_data", oData, 0);
      @(negedge clk);
    end
    reset = 1'b1;
    bits(5);
    chk("rst_no_pulse", pulses, 0);
    for (int i = 0; i < 5; i++) send(8'h36 + 8'(i), 1'b1, 10, -1);
    drain("nominal");
    chk("nominal_count", pulses, 5);
    send(8'h55, 1'b1, 0, -1);
    send(8'hAA, 1'b1, 2, -1);
    drain("b2b");
    chk("b2b_count", pulses, 7);
    p0 = pulses;
    iRX = 1'b0;
    repeat (3) @(negedge clk);
    iRX = 1'b1;
    bits(12);
    chk("glitch_no_pulse", pulses, p0);
    send(8'hA5, 1'b1, 2, 3);
    send(8'h0F, 1'b1, 2, 6);
    drain("spike");
    p0 = pulses;
    send(8'hC3, 1'b0, 2, -1);
    chk("frame_err_no_pulse", pulses, p0);
    chk("frame_err_hold", oData, model_data);
    send(8'h5A, 1'b1, 2, -1);
    drain("after_ferr");
    chk("after_ferr_count", pulses, p0 + 1);
    p0 = pulses;
    iRX = 1'b0;
    bits(30);
    iRX = 1'b1;
    bits(2);
    chk("break_no_pulse", pulses, p0);
    send(8'h81, 1'b1, 2, -1);
    drain("after_break");
    v = 8'h96;
    p0 = pulses;
    iRX = 1'b0;
    bits(1);
    for (int i = 0; i < 4; i++) begin
      iRX = v[i];
      bits(1);
    end
    iRX = v[4];
    repeat (H) @(negedge clk);
    reset = 1'b0;
    iRX = 1'b1;
    repeat (10) @(negedge clk);
    chk("midrst_valid", oValid, 0);
    chk("midrst_data", oData, 0);
    reset = 1'b1;
    model_data = 8'h00;
    bits(2);
    chk("midrst_no_pulse", pulses, p0);
    send(8'h3C, 1'b1, 2, -1);
    drain("after_midrst");
    chk("midrst_3c", oData, 8'h3C);
    for (int i = 0; i < 20; i++) begin
      int sp;
      sp = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1;
      send(8'($urandom), 1'b1, $urandom_range(0, 3), sp);
    end
    drain("random");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
